write_buffer_q: RTL and testbench
=================================

# write_buffer_q

Parametrised, coalescing write buffer between the cache's write-back port and the buffer-to-memory sender link. It holds up to DEPTH pending (address, data) stores in FIFO order, merges repeated stores to the same address, forwards buffered data to cache read misses, and drains entries one at a time through the sender's send/done handshake. It replaces the fixed single-path buffer and adds depth, coalescing, youngest-match forwarding and an explicit flush.

## Interface
- ADDR_W, 10, address width
- DATA_W, 32, data width
- DEPTH, 4, entry count; power of two, ≥2
- COALESCE, 1, 1 = merge stores to a buffered, not-in-flight address; 0 = always allocate
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  cache presents a write-back
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  valid entries
- rd_lookup  in  1  cache read-miss probe
- rd_addr  in  ADDR_W  probe address
- rd_hit  out  1  probe matches a valid entry
- rd_data  out  DATA_W  data of youngest matching entry, 0 if no hit
- send  out  1  one-cycle pulse starting a sender transfer
- out_addr  out  ADDR_W  head entry address
- out_data  out  DATA_W  head entry data
- out_write  out  1  high with send (sender write flag)
- done  in  1  sender completion pulse
- flush  in  1  level; stop accepting, drain everything
- flush_done  out  1  flush & count == 0 & state IDLE

## Operation
- Storage: circular array, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, per-entry valid bit.
- wr_ready = !full & !flush (registered state only; a same-cycle pop does not free a slot).
- Accepted write: if COALESCE and a valid entry other than the in-flight head has wr_addr, overwrite its data in place (count unchanged); else write at tail, tail+1, count+1.
- Lookup is combinational on current contents; a same-cycle write is not bypassed. Youngest match wins; in-flight head matches count.
- Drain FSM: IDLE → SEND when count≠0; SEND (send=1, out_write=1, one cycle) → WAIT; WAIT on done: pop head, go SEND if count after pop ≠0, else IDLE. done in IDLE/SEND is ignored.
- Head entry stays valid and visible to lookups until its done.
- Simultaneous accept and pop: count unchanged, both pointers advance.

## Timing
- Reset values: wr_ready 1, full 0, count 0, rd_hit 0, rd_data 0, send 0, out_write 0, out_addr 0, out_data 0, flush_done 0 (1 only if flush high); all valid bits 0, pointers 0, state IDLE.
- Reset mid-transfer abandons it; a later done is ignored.
- Write accepted at edge E0 → count visible after E0; send high in the cycle after E1.
- out_addr/out_data stable from send until the done cycle inclusive.
- Back-to-back drain: next send in the cycle after done.
- flush_done rises the cycle after the last pop's edge.

## Structure
- Package wb_pkg: default parameter constants, state enum {IDLE, SEND, WAIT}.
- Sub-module wb_match: combinational youngest-valid-match finder (address compare vector, age priority from head), used for both the coalesce and the lookup ports.

## Test plan
- Single write 0x05/0xDEADBEEF → send after 2 cycles with out_addr 0x05, out_data 0xDEADBEEF; done → count 0.
- Four writes 0x01..0x04 with done withheld → full=1, wr_ready=0, fifth write rejected; four done pulses drain in order 0x01..0x04.
- COALESCE=1: writes 0x10/0xA then 0x10/0xB while 0x10 not head-in-flight → count 1, drained data 0xB; COALESCE=0 → count 2, both drained.
- Head 0x20/0x1 in flight, write 0x20/0x2 → new entry; rd_addr 0x20 → rd_hit 1, rd_data 0x2.
- reset asserted in WAIT → all outputs reset values immediately; stray done ignored, count stays 0.
- flush with 3 entries → wr_ready 0, three drains, flush_done 1 the cycle after third pop.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and drain state type for the coalescing write buffer
// Contents:
//   WB_ADDR_W, WB_DATA_W, WB_DEPTH, WB_COALESCE : default parameter values
//   wb_state_e                                  : drain FSM states
package wb_pkg;

    localparam int WB_ADDR_W   = 10;
    localparam int WB_DATA_W   = 32;
    localparam int WB_DEPTH    = 4;
    localparam bit WB_COALESCE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_match.sv
// rtl/wb_match.sv - combinational youngest-valid-entry address matcher
// Ports:
//   valid_i     : per-slot valid mask (callers may mask out slots)
//   addr_flat_i : slot addresses, slot i at bits [i*ADDR_W +: ADDR_W]
//   head_i      : oldest slot; age increases from here, wrapping
//   key_i       : address to look for
//   hit_o       : some unmasked valid slot holds key_i
//   idx_o       : youngest such slot (head_i when no hit)
module wb_match #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [DEPTH*ADDR_W-1:0] addr_flat_i,
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [ADDR_W-1:0]       key_i,
    output logic                    hit_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match_vec;
    logic [PTR_W-1:0] slot;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign match_vec[g] = valid_i[g] && (addr_flat_i[g*ADDR_W +: ADDR_W] == key_i);
    end

    // Walk slots oldest to youngest; a later match overrides an earlier one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = head_i;
        slot  = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_i + PTR_W'(i);
            if (match_vec[slot]) begin
                hit_o = 1'b1;
                idx_o = slot;
            end
        end
    end

endmodule

// File: rtl/write_buffer_q.sv
// rtl/write_buffer_q.sv - coalescing FIFO write buffer between cache write-back and memory sender
// Ports:
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   wr_valid/wr_addr/wr_data     : write-back request; wr_ready accepts it
//   full, count                  : occupancy status
//   rd_lookup/rd_addr            : read-miss probe; rd_hit/rd_data give youngest buffered data
//   send/out_addr/out_data/out_write : start of a sender transfer of the head entry
//   done                         : sender completion; pops the head in WAIT
//   flush, flush_done            : stop accepting and report when fully drained
module write_buffer_q
    import wb_pkg::*;
#(
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int DATA_W   = WB_DATA_W,
    parameter int DEPTH    = WB_DEPTH,
    parameter bit COALESCE = WB_COALESCE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     rd_lookup,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_hit,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     send,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_write,
    input  logic                     done,
    input  logic                     flush,
    output logic                     flush_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]       addr_q [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    wb_state_e               state_q, state_d;

    logic [DEPTH*ADDR_W-1:0] addr_flat;
    logic [DEPTH-1:0]        head_mask;
    logic                    coal_hit, look_hit;
    logic [PTR_W-1:0]        coal_idx, look_idx;
    logic                    accept, merge, alloc, pop;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign addr_flat[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    // The head is locked once its transfer has started so out_data cannot change under the sender.
    assign head_mask = (state_q != IDLE) ? (DEPTH'(1) << head_q) : '0;

    wb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_coal (
        .valid_i     (valid_q & ~head_mask),
        .addr_flat_i (addr_flat),
        .head_i      (head_q),
        .key_i       (wr_addr),
        .hit_o       (coal_hit),
        .idx_o       (coal_idx)
    );

    wb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_look (
        .valid_i     (valid_q),
        .addr_flat_i (addr_flat),
        .head_i      (head_q),
        .key_i       (rd_addr),
        .hit_o       (look_hit),
        .idx_o       (look_idx)
    );

    // Readiness uses registered occupancy only; a pop in the same cycle does not open a slot.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign wr_ready = !full && !flush;
    assign accept   = wr_valid && wr_ready;
    assign merge    = COALESCE && coal_hit;
    assign alloc    = accept && !merge;
    assign pop      = (state_q == WAIT) && done;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (alloc) begin
                addr_q[tail_q] <= wr_addr;
                data_q[tail_q] <= wr_data;
            end else if (accept && merge) begin
                data_q[coal_idx] <= wr_data;
            end
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM: next state; the WAIT exit looks at occupancy after this cycle's pop and push
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (done) state_d = (count_d != '0) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        send      = (state_q == SEND);
        out_write = (state_q == SEND);
    end

    assign count      = count_q;
    assign out_addr   = addr_q[head_q];
    assign out_data   = data_q[head_q];
    assign rd_hit     = rd_lookup && look_hit;
    assign rd_data    = rd_hit ? data_q[look_idx] : '0;
    assign flush_done = flush && (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_write_buffer_q.sv
// tb/tb_write_buffer_q.sv - self-checking bench for write_buffer_q
module tb_write_buffer_q;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_lookup = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        done = 1'b0;
    logic        flush = 1'b0;

    logic        wr_ready, full, rd_hit, send, out_write, flush_done;
    logic [2:0]  count;
    logic [31:0] rd_data, out_data;
    logic [9:0]  out_addr;

    logic        wr_ready0, full0, rd_hit0, send0, out_write0, flush_done0;
    logic [2:0]  count0;
    logic [31:0] rd_data0, out_data0;
    logic [9:0]  out_addr0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    write_buffer_q #(.ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH), .COALESCE(1'b1)) dut (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .full(full), .count(count), .rd_lookup(rd_lookup), .rd_addr(rd_addr),
        .rd_hit(rd_hit), .rd_data(rd_data), .send(send), .out_addr(out_addr), .out_data(out_data),
        .out_write(out_write), .done(done), .flush(flush), .flush_done(flush_done)
    );

    write_buffer_q #(.ADDR_W(10), .DATA_W(32), .DEPTH(DEPTH), .COALESCE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready0), .full(full0), .count(count0), .rd_lookup(rd_lookup), .rd_addr(rd_addr),
        .rd_hit(rd_hit0), .rd_data(rd_data0), .send(send0), .out_addr(out_addr0), .out_data(out_data0),
        .out_write(out_write0), .done(done), .flush(flush), .flush_done(flush_done0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of the COALESCE=1 instance: an ordered list of pending stores
    // plus the phase of the current sender transfer (0 none, 1 send cycle, 2 awaiting done).
    typedef struct packed { logic [9:0] a; logic [31:0] d; } ent_t;
    ent_t mq[$];
    int   m_ph = 0;

    task automatic model_step();
        int  osz;
        int  j;
        bit  acc, pop;
        osz = mq.size();
        acc = wr_valid && (osz < DEPTH) && !flush;
        pop = (m_ph == 2) && done;
        if (acc) begin
            j = -1;
            for (int k = (m_ph != 0) ? 1 : 0; k < osz; k++)
                if (mq[k].a == wr_addr) j = k;
            if (j >= 0) mq[j].d = wr_data;
            else        mq.push_back('{a: wr_addr, d: wr_data});
        end
        if (pop) void'(mq.pop_front());
        case (m_ph)
            0: if (osz != 0) m_ph = 1;
            1: m_ph = 2;
            default: if (done) m_ph = (mq.size() != 0) ? 1 : 0;
        endcase
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ph = 0;
        end else begin
            model_step();
        end
    end

    task automatic cmp_all();
        bit          h;
        logic [31:0] d;
        h = 1'b0;
        d = '0;
        if (rd_lookup)
            foreach (mq[k]) if (mq[k].a == rd_addr) begin h = 1'b1; d = mq[k].d; end
        chk("m_count",      count,      mq.size());
        chk("m_full",       full,       mq.size() == DEPTH);
        chk("m_wr_ready",   wr_ready,   (mq.size() < DEPTH) && !flush);
        chk("m_send",       send,       m_ph == 1);
        chk("m_out_write",  out_write,  m_ph == 1);
        chk("m_rd_hit",     rd_hit,     h);
        chk("m_rd_data",    rd_data,    d);
        chk("m_flush_done", flush_done, flush && mq.size() == 0 && m_ph == 0);
        if (m_ph != 0) begin
            chk("m_out_addr", out_addr, mq[0].a);
            chk("m_out_data", out_data, mq[0].d);
        end
    endtask

    always @(negedge clock) if (chk_en) cmp_all();

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [9:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_send(input int max_cyc);
        int n = 0;
        while (send !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        chk("send_seen", send, 1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // Finish one transfer; need_send=0 when the send cycle has already gone by.
    task automatic drain(input logic [9:0] a, input logic [31:0] d, input bit need_send);
        if (need_send) begin
            wait_send(8);
            chk("drain_addr", out_addr, a);
            chk("drain_data", out_data, d);
            step();
        end else begin
            chk("drain_addr", out_addr, a);
            chk("drain_data", out_data, d);
        end
        pulse_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        chk_en = 1'b1;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_full", full, 0);
        chk("rst_send", send, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flush_done", flush_done, 0);
        reset = 1'b0;
        step();

        // single write, send two cycles after acceptance
        write(10'h005, 32'hDEADBEEF);
        chk("t1_count", count, 1);
        chk("t1_send_early", send, 0);
        step();
        chk("t1_send", send, 1);
        chk("t1_out_write", out_write, 1);
        chk("t1_out_addr", out_addr, 10'h005);
        chk("t1_out_data", out_data, 32'hDEADBEEF);
        step();
        chk("t1_send_one_cycle", send, 0);
        pulse_done();
        chk("t1_count_after", count, 0);
        step();

        // fill to DEPTH, reject fifth, drain in order
        for (int i = 1; i <= 4; i++) write(10'(i), 32'h100 + 32'(i));
        chk("t2_full", full, 1);
        chk("t2_wr_ready", wr_ready, 0);
        chk("t2_count", count, 4);
        write(10'h009, 32'h999);
        chk("t2_reject", count, 4);
        drain(10'h001, 32'h101, 1'b0);
        chk("t2_back_to_back", send, 1);
        for (int i = 2; i <= 4; i++) drain(10'(i), 32'h100 + 32'(i), 1'b1);
        chk("t2_empty", count, 0);
        step();

        // coalescing vs plain allocation
        write(10'h010, 32'hA);
        write(10'h010, 32'hB);
        chk("t3_count_c1", count, 1);
        chk("t3_count_c0", count0, 2);
        wait_send(8);
        chk("t3_data_c1", out_data, 32'hB);
        chk("t3_send_c0", send0, 1);
        chk("t3_data_c0_first", out_data0, 32'hA);
        step();
        pulse_done();
        chk("t3_count_c1_after", count, 0);
        chk("t3_count_c0_after", count0, 1);
        chk("t3_send_c0_again", send0, 1);
        chk("t3_data_c0_second", out_data0, 32'hB);
        step();
        pulse_done();
        chk("t3_count_c0_empty", count0, 0);
        step();

        // same address as in-flight head allocates; lookup returns youngest
        write(10'h020, 32'h1);
        wait_send(8);
        step();
        write(10'h020, 32'h2);
        chk("t4_count", count, 2);
        rd_lookup = 1'b1;
        rd_addr   = 10'h020;
        #1;
        chk("t4_rd_hit", rd_hit, 1);
        chk("t4_rd_data", rd_data, 32'h2);
        rd_addr = 10'h021;
        #1;
        chk("t4_rd_miss", rd_hit, 0);
        chk("t4_rd_miss_data", rd_data, 0);
        rd_lookup = 1'b0;
        drain(10'h020, 32'h1, 1'b0);
        drain(10'h020, 32'h2, 1'b1);
        chk("t4_empty", count, 0);
        step();

        // reset while awaiting done
        write(10'h030, 32'h7);
        wait_send(8);
        step();
        #1 reset = 1'b1;
        #1;
        chk("t5_count", count, 0);
        chk("t5_send", send, 0);
        chk("t5_wr_ready", wr_ready, 1);
        chk("t5_full", full, 0);
        chk("t5_out_addr", out_addr, 0);
        chk("t5_out_data", out_data, 0);
        step();
        reset = 1'b0;
        pulse_done();
        chk("t5_stray_done_count", count, 0);
        step();
        step();
        chk("t5_no_send", send, 0);

        // flush with three entries
        write(10'h041, 32'hF1);
        write(10'h042, 32'hF2);
        write(10'h043, 32'hF3);
        flush = 1'b1;
        #1;
        chk("t6_wr_ready", wr_ready, 0);
        chk("t6_flush_done_early", flush_done, 0);
        write(10'h044, 32'hF4);
        chk("t6_reject", count, 3);
        drain(10'h041, 32'hF1, 1'b0);
        drain(10'h042, 32'hF2, 1'b1);
        wait_send(8);
        chk("t6_last_addr", out_addr, 10'h043);
        step();
        chk("t6_flush_done_pending", flush_done, 0);
        pulse_done();
        chk("t6_flush_done", flush_done, 1);
        chk("t6_empty", count, 0);
        flush = 1'b0;
        #1;
        chk("t6_flush_done_drop", flush_done, 0);
        step();
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
